// File: rtl/cursor_pos_ctrl_if.sv
// Command handshake between a requester and the cursor controller.
interface cursor_pos_ctrl_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/cursor_pos_ctrl.sv
// Text-cursor position controller: queues move commands and applies at most
// one per vertical-blanking tick so the cursor never moves mid-frame.
module cursor_pos_ctrl #(
    parameter int INIT_LEFT  = 475,
    parameter int INIT_TOP   = 241,
    parameter int BOX_W      = 8,
    parameter int BOX_H      = 16,
    parameter int H_STEP     = 8,
    parameter int V_STEP     = 16,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk25,
    input  logic                  reset,
    cursor_pos_ctrl_if.slave      bus,
    input  logic                  frame_tick,
    output logic [9:0]            left,
    output logic [9:0]            right,
    output logic [8:0]            top,
    output logic [8:0]            down,
    output logic                  moved,
    output logic                  busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [9:0]    H_STEP_C = 10'(H_STEP);
    localparam logic [10:0]   H_STEP_W = 11'(H_STEP);
    localparam logic [10:0]   H_LIM_W  = 11'(H_VISIBLE - BOX_W);
    localparam logic [9:0]    H_LIM_C  = 10'(H_VISIBLE - BOX_W);
    localparam logic [8:0]    V_STEP_C = 9'(V_STEP);
    localparam logic [9:0]    V_STEP_W = 10'(V_STEP);
    localparam logic [9:0]    V_LIM_W  = 10'(V_VISIBLE - BOX_H);
    localparam logic [8:0]    V_LIM_C  = 9'(V_VISIBLE - BOX_H);
    localparam logic [9:0]    INIT_L_C = 10'(INIT_LEFT);
    localparam logic [8:0]    INIT_T_C = 9'(INIT_TOP);
    localparam logic [9:0]    BOX_W_M1 = 10'(BOX_W - 1);
    localparam logic [8:0]    BOX_H_M1 = 9'(BOX_H - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, APPLY} state_t;

    state_t        state_q, state_d;
    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [9:0]    left_q, left_d, right_q;
    logic [8:0]    top_q, top_d, down_q;
    logic          moved_q, moved_d;
    logic          push, pop;
    logic [10:0]   sum_h;
    logic [9:0]    sum_v;

    assign bus.cmd_ready = (count_q < DEPTH_C);
    assign push  = bus.cmd_valid && bus.cmd_ready;
    assign sum_h = {1'b0, left_q} + H_STEP_W;
    assign sum_v = {1'b0, top_q} + V_STEP_W;

    // Occupancy after this cycle's push/pop; both together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge clk25) begin
        if (push) mem_q[wr_ptr_q] <= bus.cmd;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: wait for a queued command, then for a blanking tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (count_q != '0) state_d = WAIT_FRAME;
            WAIT_FRAME: if (frame_tick)    state_d = APPLY;
            APPLY:      state_d = (count_d != '0) ? WAIT_FRAME : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // FSM outputs: the head is consumed in the single APPLY cycle.
    always_comb begin
        pop  = (state_q == APPLY);
        busy = (state_q != IDLE);
    end

    // New position for the head command, saturating at the screen edges.
    always_comb begin
        left_d = left_q;
        top_d  = top_q;
        if (pop) begin
            case (mem_q[rd_ptr_q])
                3'd0: left_d = (left_q < H_STEP_C) ? '0 : left_q - H_STEP_C;
                3'd1: left_d = (sum_h > H_LIM_W) ? H_LIM_C : sum_h[9:0];
                3'd2: top_d  = (top_q < V_STEP_C) ? '0 : top_q - V_STEP_C;
                3'd3: top_d  = (sum_v > V_LIM_W) ? V_LIM_C : sum_v[8:0];
                3'd4: begin
                    left_d = INIT_L_C;
                    top_d  = INIT_T_C;
                end
                default: ;
            endcase
        end
        moved_d = pop && ((left_d != left_q) || (top_d != top_q));
    end

    // Position registers; far borders are registered alongside so they never skew.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            left_q  <= INIT_L_C;
            top_q   <= INIT_T_C;
            right_q <= INIT_L_C + BOX_W_M1;
            down_q  <= INIT_T_C + BOX_H_M1;
            moved_q <= 1'b0;
        end else begin
            left_q  <= left_d;
            top_q   <= top_d;
            right_q <= left_d + BOX_W_M1;
            down_q  <= top_d + BOX_H_M1;
            moved_q <= moved_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign top   = top_q;
    assign down  = down_q;
    assign moved = moved_q;
endmodule
